// File: rtl/nap_controller.sv
// Nap timer front-end: edits a BCD hh:mm:ss preset, loads it into an external
// down-counting time register, runs/pauses it and raises a timed alarm at zero.
module nap_controller #(
    parameter int unsigned ALARM_CYCLES = 50000000,
    parameter int unsigned PRESET_M10   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_start,
    input  logic       zero,
    output logic       wr,
    output logic       run,
    output logic [3:0] set_h10,
    output logic [3:0] set_h1,
    output logic [3:0] set_m10,
    output logic [3:0] set_m1,
    output logic [3:0] set_s10,
    output logic [3:0] set_s1,
    output logic [2:0] cursor,
    output logic [2:0] state,
    output logic       alarm
);

    localparam int unsigned AW = $clog2(ALARM_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EDIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_ALARM = 3'd5
    } state_t;

    state_t          cur, nxt;
    logic [2:0]      nxt_cursor;
    logic [1:0]      guard, nxt_guard;
    logic [AW-1:0]   acnt, nxt_acnt;
    logic            inc_digit;
    logic            all_zero;
    logic            any_btn;
    logic [3:0]      h10_inc;

    function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

    assign all_zero = (set_h10 == '0) && (set_h1 == '0) && (set_m10 == '0) &&
                      (set_m1 == '0) && (set_s10 == '0) && (set_s1 == '0);
    assign any_btn  = btn_set | btn_start | btn_next | btn_up;
    assign state    = cur;
    assign h10_inc  = bump(set_h10, 4'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur    <= S_IDLE;
            cursor <= '0;
            guard  <= '0;
            acnt   <= '0;
            wr     <= 1'b0;
            run    <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            cur    <= nxt;
            cursor <= nxt_cursor;
            guard  <= nxt_guard;
            acnt   <= nxt_acnt;
            // Outputs registered from the next state so they track the state register exactly.
            wr     <= (nxt == S_LOAD);
            run    <= (nxt == S_RUN);
            alarm  <= (nxt == S_ALARM);
        end
    end

    always_comb begin
        nxt        = cur;
        nxt_cursor = cursor;
        nxt_guard  = '0;
        nxt_acnt   = '0;
        inc_digit  = 1'b0;
        case (cur)
            S_IDLE: begin
                if (btn_set) begin
                    nxt        = S_EDIT;
                    nxt_cursor = '0;
                end else if (btn_start && !all_zero) begin
                    nxt = S_LOAD;
                end
            end
            S_EDIT: begin
                if (btn_set) begin
                    nxt = S_IDLE;
                end else if (btn_start) begin
                    if (!all_zero) nxt = S_LOAD;
                end else if (btn_next) begin
                    nxt_cursor = (cursor == 3'd5) ? 3'd0 : cursor + 3'd1;
                end else if (btn_up) begin
                    inc_digit = 1'b1;
                end
            end
            S_LOAD: begin
                nxt       = S_RUN;
                nxt_guard = 2'd2;
            end
            S_RUN: begin
                // While the guard is pending the zero flag is stale from the previous count.
                if (guard != '0) begin
                    nxt_guard = guard - 2'd1;
                    if (btn_set)        nxt = S_IDLE;
                    else if (btn_start) nxt = S_PAUSE;
                end else if (zero) begin
                    nxt = S_ALARM;
                end else if (btn_set) begin
                    nxt = S_IDLE;
                end else if (btn_start) begin
                    nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (btn_set)        nxt = S_IDLE;
                else if (btn_start) nxt = S_RUN;
            end
            S_ALARM: begin
                if (any_btn || acnt == AW'(ALARM_CYCLES - 1)) nxt = S_IDLE;
                else nxt_acnt = acnt + AW'(1);
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            set_h10 <= '0;
            set_h1  <= '0;
            set_m10 <= 4'(PRESET_M10);
            set_m1  <= '0;
            set_s10 <= '0;
            set_s1  <= '0;
        end else if (inc_digit) begin
            case (cursor)
                3'd0: begin
                    set_h10 <= h10_inc;
                    if (h10_inc == 4'd2 && set_h1 > 4'd3) set_h1 <= '0;
                end
                3'd1: set_h1  <= bump(set_h1, (set_h10 == 4'd2) ? 4'd3 : 4'd9);
                3'd2: set_m10 <= bump(set_m10, 4'd5);
                3'd3: set_m1  <= bump(set_m1, 4'd9);
                3'd4: set_s10 <= bump(set_s10, 4'd5);
                3'd5: set_s1  <= bump(set_s1, 4'd9);
                default: ;
            endcase
        end
    end

endmodule
